// File: rtl/direction_validator.sv
// direction_validator: walks the padded 10x10 board from a candidate cell
// along one direction. It reports whether that direction flanks at least one
// opponent piece and can optionally flip the flanked pieces to the mover's
// colour.
module direction_validator #(
  parameter int ADDR_W      = 7,
  parameter int BOARD_CELLS = 100,
  parameter int MAX_RUN     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic              enable,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [4:0]        step_in,
  input  logic [1:0]        player_i,
  input  logic              flip_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [1:0]        mem_data_i,
  output logic              mem_wr_o,
  output logic [1:0]        mem_wdata_o,
  output logic              s_done_o,
  output logic              dir_status_o,
  output logic              busy_o
);

  // The extra top bit of the cursor catches both underflow and overflow.
  localparam int CW = ADDR_W + 1;
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam logic [CW-1:0] CELLS   = CW'(BOARD_CELLS);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_RUN);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_EVAL, S_FLIP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [4:0]        step_q, step_d;
  logic [1:0]        player_q, player_d;
  logic              flip_q, flip_d;
  logic [CW-1:0]     cur_q, cur_d;
  logic [RW-1:0]     run_q, run_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [CW-1:0]     stepx_q, stepx_d;
  logic [1:0]        opp;
  logic              pvalid;

  // Opponent is the mover colour with its bits swapped; 00/11 movers never flank.
  assign opp     = {player_q[0], player_q[1]};
  assign pvalid  = player_q[0] ^ player_q[1];
  assign stepx_q = {{(CW-5){step_q[4]}}, step_q};

  // Next-state, datapath updates and memory-port outputs.
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    step_d      = step_q;
    player_d    = player_q;
    flip_d      = flip_q;
    cur_d       = cur_q;
    run_d       = run_q;
    dir_d       = dir_q;
    addr_d      = addr_q;
    mem_wr_o    = 1'b0;
    mem_wdata_o = 2'b00;
    stepx_d     = stepx_q;

    case (state_q)
      S_IDLE: begin
        if (ld) begin
          start_d  = start_addr_i;
          step_d   = step_in;
          player_d = player_i;
          flip_d   = flip_i;
        end
        stepx_d = {{(CW-5){step_d[4]}}, step_d};
        if (enable) begin
          cur_d   = {1'b0, start_d} + stepx_d;
          run_d   = '0;
          dir_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        addr_d = cur_q[ADDR_W-1:0];
        if (cur_q[CW-1] || cur_q >= CELLS) begin
          dir_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!pvalid) begin
          dir_d   = 1'b0;
          state_d = S_DONE;
        end else if (mem_data_i == opp) begin
          run_d = run_q + 1'b1;
          cur_d = cur_q + stepx_q;
          if (run_d == RUN_MAX) begin
            dir_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else if (mem_data_i == player_q) begin
          dir_d = (run_q != '0);
          if (run_q != '0 && flip_q) begin
            // Restart the walk at the first flanked cell for the write pass.
            cur_d   = {1'b0, start_q} + stepx_q;
            state_d = S_FLIP;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          dir_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_FLIP: begin
        mem_wr_o    = 1'b1;
        mem_wdata_o = player_q;
        addr_d      = cur_q[ADDR_W-1:0];
        cur_d       = cur_q + stepx_q;
        run_d       = run_q - 1'b1;
        if (run_q == RW'(1)) begin
          dir_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr_o   = addr_d;
  assign s_done_o     = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign dir_status_o = dir_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      start_q  <= '0;
      step_q   <= '0;
      player_q <= '0;
      flip_q   <= 1'b0;
      cur_q    <= '0;
      run_q    <= '0;
      dir_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      step_q   <= step_d;
      player_q <= player_d;
      flip_q   <= flip_d;
      cur_q    <= cur_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
    end
  end

endmodule
